linecard_read_scheduler: RTL and testbench

LINECARD_READ_SCHEDULER -- requirements
Module: linecard_read_scheduler

---
 rtl/linecard_read_scheduler_pkg.sv | 6 +
 rtl/linecard_read_scheduler_rr_priority_picker.sv | 25 ++
 rtl/linecard_read_scheduler.sv | 81 ++++++++
 tb/tb_linecard_read_scheduler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/linecard_read_scheduler_pkg.sv
// LineCardSchedPkg: shared scheduler state encoding and default sizing constants.
package LineCardSchedPkg;
  typedef enum logic [1:0] {IDLE, ARB, GRANT, BUSY} sched_state_t;
  localparam int DEFAULT_NUM_PORTS = 24;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;
endpackage

// File: rtl/linecard_read_scheduler_rr_priority_picker.sv
// rr_priority_picker: combinational circular first-set search starting just after last.
module rr_priority_picker #(
  parameter int N = 24,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] index
);
  logic [W-1:0] idx;
  // Walk offsets from farthest to nearest so the nearest set bit overwrites last.
  always_comb begin
    found = 1'b0;
    index = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(last) + k) % N);
      if (req[idx]) begin
        found = 1'b1;
        index = idx;
      end
    end
  end
endmodule

// File: rtl/linecard_read_scheduler.sv
// linecard_read_scheduler: round-robin grant of a shared URAM read port across ingress FIFOs,
// with per-FIFO abort and a BUSY watchdog.
module linecard_read_scheduler
  import LineCardSchedPkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int PTR_BITS = 13,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic                                clk,
  input  logic                                areset_n,
  input  logic [NUM_PORTS-1:0][PTR_BITS-1:0]  wr_ptr_committed,
  input  logic [NUM_PORTS-1:0][PTR_BITS-1:0]  rd_ptr,
  input  logic [NUM_PORTS-1:0]                rd_ptr_reset,
  input  logic [NUM_PORTS-1:0]                port_mask,
  output logic                                grant_valid,
  output logic [PW-1:0]                       grant_port,
  input  logic                                grant_ready,
  input  logic                                frame_done,
  output logic                                busy,
  output logic                                abort,
  output logic                                timeout
);
  sched_state_t state, state_d;
  logic [NUM_PORTS-1:0] req_d, req_q;
  logic [PW-1:0] last_grant, pick;
  logic [TW-1:0] wd;
  logic found, accept;
  always_comb begin
    req_d = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      req_d[i] = (wr_ptr_committed[i] != rd_ptr[i]) & ~rd_ptr_reset[i] & ~port_mask[i];
  end
  rr_priority_picker #(.N(NUM_PORTS)) u_picker (
    .req   (req_q),
    .last  (last_grant),
    .found (found),
    .index (pick)
  );
  // frame_done beats a FIFO reset in BUSY; a FIFO reset beats grant_ready in GRANT.
  always_comb begin
    state_d = state;
    abort = 1'b0;
    timeout = 1'b0;
    accept = 1'b0;
    case (state)
      IDLE: state_d = |req_q ? ARB : IDLE;
      ARB: state_d = found ? GRANT : IDLE;
      GRANT: begin
        abort = rd_ptr_reset[grant_port];
        accept = grant_ready & ~abort;
        state_d = abort ? IDLE : grant_ready ? BUSY : GRANT;
      end
      BUSY: begin
        abort = rd_ptr_reset[grant_port] & ~frame_done;
        timeout = ~frame_done & ~abort & (wd == TW'(TIMEOUT_CYCLES - 1));
        state_d = (frame_done | abort | timeout) ? IDLE : BUSY;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) begin
      req_q <= '0;
      grant_port <= '0;
      last_grant <= PW'(NUM_PORTS - 1);
      wd <= '0;
    end else begin
      req_q <= req_d;
      if (state == ARB && found) grant_port <= pick;
      if (accept || abort) last_grant <= grant_port;
      wd <= (state == BUSY) ? wd + TW'(1) : '0;
    end
  assign grant_valid = (state == GRANT);
  assign busy = (state == BUSY);
endmodule

// File: tb/tb_linecard_read_scheduler.sv
// tb_linecard_read_scheduler: directed checks of arbitration order, hold, abort, watchdog and pointer compare.
module tb_linecard_read_scheduler;
  logic clk = 1'b0;
  logic areset_n;
  logic [23:0][12:0] wr, rd;
  logic [23:0] prst, mask;
  logic gv, ready, done, busy, abort, timeout;
  logic [4:0] gp;
  int checks = 0;
  int errors = 0;

  linecard_read_scheduler #(.NUM_PORTS(24), .PTR_BITS(13), .TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .areset_n         (areset_n),
    .wr_ptr_committed (wr),
    .rd_ptr           (rd),
    .rd_ptr_reset     (prst),
    .port_mask        (mask),
    .grant_valid      (gv),
    .grant_port       (gp),
    .grant_ready      (ready),
    .frame_done       (done),
    .busy             (busy),
    .abort            (abort),
    .timeout          (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    wr = '0;
    rd = '0;
    prst = '0;
    mask = '0;
    ready = 1'b0;
    done = 1'b0;
    step();
    areset_n = 1'b1;
  endtask

  task automatic wait_gv();
    int n = 0;
    while (!gv && n < 10) begin
      step();
      n++;
    end
    chk("grant_wait", gv, 1);
  endtask

  task automatic serve(input string tag, input int port);
    wait_gv();
    chk(tag, gp, port);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("serve_busy", busy, 1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("serve_idle", busy, 0);
  endtask

  initial begin
    do_reset();
    areset_n = 1'b0;
    step();
    chk("rst_gv", gv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_abort", abort, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_gp", gp, 0);

    // grant to port 5 appears on the third edge after release
    do_reset();
    wr[5] = 13'd1;
    step();
    chk("c1_gv", gv, 0);
    step();
    chk("c2_gv", gv, 0);
    step();
    chk("c3_gv", gv, 1);
    chk("c3_gp", gp, 5);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("p5_busy", busy, 1);
    chk("p5_gv", gv, 0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("p5_idle", busy, 0);

    // round-robin order 0, 3, 23, 0, 3
    do_reset();
    wr[0] = 13'd1;
    wr[3] = 13'd1;
    wr[23] = 13'd1;
    serve("rr0", 0);
    serve("rr1", 3);
    serve("rr2", 23);
    serve("rr3", 0);
    serve("rr4", 3);

    // grant to port 7 held for 10 cycles; masking it must not cancel
    do_reset();
    wr[7] = 13'd1;
    wait_gv();
    chk("hold_gp", gp, 7);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) mask[7] = 1'b1;
      step();
      chk("hold_gv", gv, 1);
      chk("hold_gp", gp, 7);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("hold_busy", busy, 1);
    done = 1'b1;
    step();
    done = 1'b0;

    // FIFO reset with frame_done: no abort; FIFO reset alone: abort
    do_reset();
    wr[2] = 13'd1;
    wait_gv();
    chk("ab_gp", gp, 2);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("ab_busy", busy, 1);
    prst[2] = 1'b1;
    done = 1'b1;
    #1;
    chk("ab_done_wins", abort, 0);
    step();
    prst[2] = 1'b0;
    done = 1'b0;
    chk("ab_done_idle", busy, 0);
    wait_gv();
    chk("ab2_gp", gp, 2);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("ab2_busy", busy, 1);
    prst[2] = 1'b1;
    #1;
    chk("ab2_abort", abort, 1);
    step();
    chk("ab2_idle_busy", busy, 0);
    chk("ab2_idle_gv", gv, 0);
    chk("ab2_abort_end", abort, 0);
    prst[2] = 1'b0;

    // abort wins over grant_ready in GRANT
    do_reset();
    wr[6] = 13'd1;
    wait_gv();
    ready = 1'b1;
    prst[6] = 1'b1;
    #1;
    chk("gr_abort", abort, 1);
    step();
    ready = 1'b0;
    prst[6] = 1'b0;
    chk("gr_abort_busy", busy, 0);
    chk("gr_abort_gv", gv, 0);

    // watchdog: timeout on 16th BUSY cycle, busy drops next cycle
    do_reset();
    wr[4] = 13'd1;
    wait_gv();
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("wd_busy", busy, 1);
    chk("wd_t0", timeout, 0);
    for (int i = 1; i < 15; i++) begin
      step();
      chk("wd_early", timeout, 0);
    end
    step();
    chk("wd_pulse", timeout, 1);
    chk("wd_pulse_busy", busy, 1);
    step();
    chk("wd_after_busy", busy, 0);
    chk("wd_after_to", timeout, 0);

    // wrap-around pointers request
    do_reset();
    wr[9] = 13'h0000;
    rd[9] = 13'h1FFF;
    serve("wrap_gp", 9);

    // equal pointers and masked port never granted
    do_reset();
    wr[9] = 13'h0AB;
    rd[9] = 13'h0AB;
    wr[11] = 13'd1;
    wr[12] = 13'd1;
    mask[12] = 1'b1;
    serve("eq_gp0", 11);
    serve("eq_gp1", 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
